// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin burst arbiter sharing one fifo push port
// Optional per-requester beat counters: define FIFO_PUSH_ARBITER_STATS_EN.
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     fifo_push_o,
  output logic [WIDTH-1:0]         fifo_push_data_o,
  input  logic                     fifo_full_i,
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  input  logic                     stat_clr_i,
  output logic [NUM_REQ*32-1:0]    stat_beats_o,
`endif
  output logic                     busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_ptr;
  logic [NUM_REQ-1:0] grant_q;
  logic [CNT_W-1:0]   beat_cnt;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  int                 idx;
  logic               in_burst;
  logic               xfer;
  logic               release_c;

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(last_ptr) + i) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign in_burst  = (state == ST_BURST);
  assign xfer      = in_burst && req_valid_i[owner] && !fifo_full_i;
  assign release_c = xfer && (req_last_i[owner] || (beat_cnt == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    req_ready_o = '0;
    if (in_burst) begin
      req_ready_o[owner] = !fifo_full_i;
    end
  end

  assign fifo_push_o      = xfer;
  assign fifo_push_data_o = in_burst ? req_data_i[owner*WIDTH +: WIDTH] : '0;
  assign grant_o          = grant_q;
  assign busy_o           = in_burst;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last_ptr <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_BURST;
            owner    <= pick;
            grant_q  <= NUM_REQ'(1) << pick;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (release_c) begin
            state    <= ST_IDLE;
            last_ptr <= owner;
            grant_q  <= '0;
          end
        end
      endcase
    end
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (stat_clr_i) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (xfer) begin
      stat_q[owner] <= stat_q[owner] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats_o[g*32 +: 32] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - directed self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

  logic         clk_i;
  logic         rstn_i;
  logic [3:0]   req_valid_i;
  logic [127:0] req_data_i;
  logic [3:0]   req_last_i;
  logic [3:0]   req_ready_o;
  logic [3:0]   grant_o;
  logic         fifo_push_o;
  logic [31:0]  fifo_push_data_o;
  logic         fifo_full_i;
  logic         busy_o;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic         stat_clr_i;
  logic [127:0] stat_beats_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;

  fifo_push_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(8)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .req_valid_i      (req_valid_i),
    .req_data_i       (req_data_i),
    .req_last_i       (req_last_i),
    .req_ready_o      (req_ready_o),
    .grant_o          (grant_o),
    .fifo_push_o      (fifo_push_o),
    .fifo_push_data_o (fifo_push_data_o),
    .fifo_full_i      (fifo_full_i),
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    .stat_clr_i       (stat_clr_i),
    .stat_beats_o     (stat_beats_o),
`endif
    .busy_o           (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i      = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    fifo_full_i = 1'b0;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    stat_clr_i  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", req_ready_o, 4'b0000);
    chk("rst_push", fifo_push_o, 1'b0);
    chk("rst_data", fifo_push_data_o, 32'h0);
    rstn_i = 1'b1;

    // single requester, 3-beat burst
    req_valid_i = 4'b0001;
    req_data_i[31:0] = 32'hA1;
    #1;
    chk("t1_idle_push", fifo_push_o, 1'b0);
    tick();
    chk("t1_grant", grant_o, 4'b0001);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_ready", req_ready_o, 4'b0001);
    chk("t1_push1", fifo_push_o, 1'b1);
    chk("t1_data1", fifo_push_data_o, 32'hA1);
    tick();
    req_data_i[31:0] = 32'hA2;
    #1;
    chk("t1_push2", fifo_push_o, 1'b1);
    chk("t1_data2", fifo_push_data_o, 32'hA2);
    tick();
    req_data_i[31:0] = 32'hA3;
    req_last_i = 4'b0001;
    #1;
    chk("t1_push3", fifo_push_o, 1'b1);
    chk("t1_data3", fifo_push_data_o, 32'hA3);
    tick();
    req_valid_i = '0;
    req_last_i  = '0;
    #1;
    chk("t1_rel_grant", grant_o, 4'b0000);
    chk("t1_rel_busy", busy_o, 1'b0);
    chk("t1_rel_push", fifo_push_o, 1'b0);
    chk("t1_rel_data", fifo_push_data_o, 32'h0);

    // all requesters, 1-beat bursts, round robin from reset
    rstn_i = 1'b0;
    #2;
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) req_data_i[i*32 +: 32] = 32'hB0 + i;
    req_last_i  = 4'b1111;
    req_valid_i = 4'b1111;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 1) begin
        chk("t2_grant", grant_o, 4'b0001 << (((c - 1) / 2) % 4));
        chk("t2_data", fifo_push_data_o, 32'hB0 + (((c - 1) / 2) % 4));
      end else begin
        chk("t2_bubble", grant_o, 4'b0000);
      end
      if (fifo_push_o) n_push++;
      tick();
    end
    chk("t2_push_count", n_push, 5);
    req_valid_i = '0;
    req_last_i  = '0;
    #1;
    chk("t2_end_grant", grant_o, 4'b0000);

    // long burst from requester 2 is cut at MAX_BURST
    req_valid_i = 4'b0100;
    tick();
    for (int b = 0; b < 8; b++) begin
      req_data_i[64 +: 32] = 32'h200 + b;
      #1;
      chk("t3a_grant", grant_o, 4'b0100);
      chk("t3a_push", fifo_push_o, 1'b1);
      chk("t3a_data", fifo_push_data_o, 32'h200 + b);
      tick();
    end
    chk("t3a_rel_grant", grant_o, 4'b0000);
    chk("t3a_rel_push", fifo_push_o, 1'b0);
    tick();
    chk("t3_regrant2", grant_o, 4'b0100);
    req_valid_i = 4'b1100;
    req_last_i  = 4'b1000;
    req_data_i[96 +: 32] = 32'h300;
    for (int b = 8; b < 16; b++) begin
      req_data_i[64 +: 32] = 32'h200 + b;
      #1;
      chk("t3b_grant", grant_o, 4'b0100);
      chk("t3b_data", fifo_push_data_o, 32'h200 + b);
      tick();
    end
    chk("t3b_rel_grant", grant_o, 4'b0000);
    tick();
    chk("t3_grant3", grant_o, 4'b1000);
    chk("t3_data3", fifo_push_data_o, 32'h300);
    tick();
    req_valid_i = '0;
    req_last_i  = '0;
    #1;
    chk("t3_end_grant", grant_o, 4'b0000);

    // back-pressure after 3 beats freezes the burst
    req_valid_i = 4'b0010;
    tick();
    for (int b = 0; b < 3; b++) begin
      req_data_i[32 +: 32] = 32'h100 + b;
      #1;
      chk("t4_pre_push", fifo_push_o, 1'b1);
      tick();
    end
    fifo_full_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_full_ready", req_ready_o, 4'b0000);
      chk("t4_full_push", fifo_push_o, 1'b0);
      chk("t4_full_grant", grant_o, 4'b0010);
      tick();
    end
    fifo_full_i = 1'b0;
    for (int b = 3; b < 8; b++) begin
      req_data_i[32 +: 32] = 32'h100 + b;
      #1;
      chk("t4_post_push", fifo_push_o, 1'b1);
      chk("t4_post_data", fifo_push_data_o, 32'h100 + b);
      tick();
    end
    req_valid_i = '0;
    #1;
    chk("t4_rel_grant", grant_o, 4'b0000);
    chk("t4_rel_busy", busy_o, 1'b0);

    // asynchronous reset during beat 2
    req_valid_i = 4'b1000;
    req_data_i[96 +: 32] = 32'h3A;
    tick();
    chk("t5_grant3", grant_o, 4'b1000);
    tick();
    chk("t5_beat2_push", fifo_push_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    chk("t5_rst_grant", grant_o, 4'b0000);
    chk("t5_rst_push", fifo_push_o, 1'b0);
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_ready", req_ready_o, 4'b0000);
    #2;
    rstn_i = 1'b1;
    req_valid_i = 4'b1001;
    req_data_i[31:0] = 32'h0C;
    tick();
    chk("t5_grant0", grant_o, 4'b0001);
    chk("t5_data0", fifo_push_data_o, 32'h0C);
    req_last_i = 4'b1001;
    tick();
    req_valid_i = '0;
    req_last_i  = '0;

`ifdef FIFO_PUSH_ARBITER_STATS_EN
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    req_valid_i = 4'b0010;
    tick();
    tick();
    tick();
    req_last_i = 4'b0010;
    tick();
    req_valid_i = 4'b1000;
    req_last_i  = '0;
    tick();
    repeat (4) tick();
    req_last_i = 4'b1000;
    tick();
    req_valid_i = '0;
    req_last_i  = '0;
    #1;
    chk("st_req0", stat_beats_o[31:0], 32'd0);
    chk("st_req1", stat_beats_o[63:32], 32'd3);
    chk("st_req2", stat_beats_o[95:64], 32'd0);
    chk("st_req3", stat_beats_o[127:96], 32'd5);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    #1;
    chk("st_clr", stat_beats_o, 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
